// File: rtl/icache_pfetch_ctrl.sv
// Four-entry Icache miss/prefetch tracker: round-robin issue to memory, tag-matched fill return.
// Issue is same-cycle combinational, fill is registered one cycle after the matching data tag.
module icache_pfetch_ctrl #(
  parameter int ADDR_W = 13,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  output logic              alloc_ready_o,
  output logic              alloc_dup_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic [TAG_W-1:0]  mem_rsp_tag_i,
  input  logic [TAG_W-1:0]  mem_data_tag_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              fill_valid_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [DATA_W-1:0] fill_data_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {ST_INV, ST_PEND, ST_WAIT} st_e;

  st_e               st_q     [4];
  st_e               st_d     [4];
  logic [ADDR_W-1:0] addr_q   [4];
  logic [ADDR_W-1:0] addr_d   [4];
  logic [TAG_W-1:0]  tag_q    [4];
  logic [TAG_W-1:0]  tag_d    [4];
  logic [3:0]        squash_q, squash_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  logic [3:0] inv_vec, pend_vec;
  logic       dup;
  logic       gnt_vld, ret_hit, alloc_vld, alloc_fire, issue_fire;
  logic [1:0] gnt_idx, ret_idx, alloc_idx, scan_idx;

  always_comb begin
    inv_vec   = '0;
    pend_vec  = '0;
    dup       = 1'b0;
    ret_hit   = 1'b0;
    ret_idx   = 2'd0;
    alloc_vld = 1'b0;
    alloc_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      inv_vec[i]  = (st_q[i] == ST_INV);
      pend_vec[i] = (st_q[i] == ST_PEND);
      if (st_q[i] != ST_INV && addr_q[i] == alloc_addr_i)
        dup = 1'b1;
      if (st_q[i] == ST_WAIT && mem_data_tag_i != '0 && tag_q[i] == mem_data_tag_i) begin
        ret_hit = 1'b1;
        ret_idx = 2'(i);
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (inv_vec[i]) begin
        alloc_vld = 1'b1;
        alloc_idx = 2'(i);
      end
    end

    // Rotating priority: first PEND entry found scanning upward from rr_ptr, wrapping.
    gnt_vld  = 1'b0;
    gnt_idx  = 2'd0;
    scan_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr_q + 2'(i);
      if (!gnt_vld && pend_vec[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end

    alloc_fire = alloc_valid_i & alloc_vld & ~dup & ~flush_i;
    issue_fire = gnt_vld & (mem_rsp_tag_i != '0);

    for (int i = 0; i < 4; i++) begin
      st_d[i]     = st_q[i];
      addr_d[i]   = addr_q[i];
      tag_d[i]    = tag_q[i];
      squash_d[i] = squash_q[i];
      if (flush_i) begin
        if (st_q[i] == ST_PEND) st_d[i] = ST_INV;
        if (st_q[i] == ST_WAIT) squash_d[i] = 1'b1;
      end
      if (issue_fire && gnt_idx == 2'(i)) begin
        st_d[i]     = ST_WAIT;
        tag_d[i]    = mem_rsp_tag_i;
        squash_d[i] = flush_i;
      end
      if (ret_hit && ret_idx == 2'(i)) begin
        st_d[i]     = ST_INV;
        squash_d[i] = 1'b0;
      end
      if (alloc_fire && alloc_idx == 2'(i)) begin
        st_d[i]     = ST_PEND;
        addr_d[i]   = alloc_addr_i;
        tag_d[i]    = '0;
        squash_d[i] = 1'b0;
      end
    end

    rr_ptr_d     = issue_fire ? gnt_idx + 2'd1 : rr_ptr_q;
    fill_valid_d = ret_hit & ~squash_q[ret_idx];
    fill_addr_d  = fill_valid_d ? addr_q[ret_idx] : fill_addr_q;
    fill_data_d  = fill_valid_d ? mem_data_i : fill_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]   <= ST_INV;
        addr_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      squash_q     <= '0;
      rr_ptr_q     <= 2'd0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
        tag_q[i]  <= tag_d[i];
      end
      squash_q     <= squash_d;
      rr_ptr_q     <= rr_ptr_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
    end
  end

  // Ready is masked during reset so every combinational output reads 0 while rst_n is low.
  assign alloc_ready_o   = rst_n & alloc_vld;
  assign alloc_dup_o     = dup;
  assign mem_req_valid_o = gnt_vld;
  assign mem_req_addr_o  = gnt_vld ? addr_q[gnt_idx] : '0;
  assign busy_o          = ~&inv_vec;
  assign fill_valid_o    = fill_valid_q;
  assign fill_addr_o     = fill_addr_q;
  assign fill_data_o     = fill_data_q;

endmodule
